// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage MIPS pipeline registers.
//   - Default generic widths for pipe_stage_reg.
//   - Per-stage control/data bundle widths (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   - Bit offsets used to pack and unpack the bundles.
//   - NOP_CTRL: the control value that makes a stage behave as a bubble.
//   - stage_act_e: the single action a stage register takes in a cycle.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

    // Generic defaults for pipe_stage_reg
    localparam int DEF_CTRL_W = 16;
    localparam int DEF_DATA_W = 128;
    localparam int DEF_PC_W   = 32;

    // All-zero control is a NOP: no register write, no memory access, no branch.
    localparam logic [DEF_CTRL_W-1:0] NOP_CTRL = '0;

    // Per-stage bundle widths
    localparam int IF_ID_CTRL_W  = 1;    // only the valid-carrying slot, no decoded ctrl yet
    localparam int IF_ID_DATA_W  = 32;   // raw fetched instruction
    localparam int ID_EX_CTRL_W  = 16;
    localparam int ID_EX_DATA_W  = 128;
    localparam int EX_MEM_CTRL_W = 8;
    localparam int EX_MEM_DATA_W = 80;
    localparam int MEM_WB_CTRL_W = 4;
    localparam int MEM_WB_DATA_W = 72;

    // Control bundle bit positions (ID/EX layout; later stages keep the low bits)
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_REGDST   = 6;
    localparam int CTRL_ALUOP_LO = 7;
    localparam int CTRL_ALUOP_W  = 4;
    localparam int CTRL_JUMP     = 11;

    // ID/EX data bundle field offsets
    localparam int ID_EX_IMM_OFS   = 0;
    localparam int ID_EX_REG1_OFS  = 32;
    localparam int ID_EX_REG2_OFS  = 64;
    localparam int ID_EX_RS_OFS    = 96;
    localparam int ID_EX_RT_OFS    = 101;
    localparam int ID_EX_RD_OFS    = 106;
    localparam int ID_EX_SHAMT_OFS = 111;
    localparam int REG_IDX_W       = 5;

    // EX/MEM data bundle field offsets
    localparam int EX_MEM_ALU_OFS  = 0;
    localparam int EX_MEM_WDAT_OFS = 32;
    localparam int EX_MEM_WREG_OFS = 64;

    // MEM/WB data bundle field offsets
    localparam int MEM_WB_RDAT_OFS = 0;
    localparam int MEM_WB_ALU_OFS  = 32;
    localparam int MEM_WB_WREG_OFS = 64;

    // Action taken by a stage register this cycle (reset handled separately).
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2,
        ACT_FLUSH  = 2'd3
    } stage_act_e;

    // Extract the destination register index from an ID/EX data bundle.
    function automatic logic [REG_IDX_W-1:0] id_ex_rd(input logic [ID_EX_DATA_W-1:0] data);
        return data[ID_EX_RD_OFS +: REG_IDX_W];
    endfunction

    // Extract the rt register index from an ID/EX data bundle (load-use check).
    function automatic logic [REG_IDX_W-1:0] id_ex_rt(input logic [ID_EX_DATA_W-1:0] data);
        return data[ID_EX_RT_OFS +: REG_IDX_W];
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
// Bundle of signals between an upstream stage, a pipeline register and the
// hazard unit.
//   Upstream -> register : in_valid, in_ctrl, in_data, in_pc, in_npc, in_instr
//   Hazard   -> register : hold, bubble, flush
//   Register -> upstream : in_ready
//   Register -> downstream: out_valid, out_ctrl, out_data, out_pc, out_npc,
//                           out_instr
// Modports:
//   slave  - the pipeline register itself.
//   master - whatever drives it (upstream stage + hazard unit, or a bench).
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int PC_W   = 32
);
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic [PC_W-1:0]   in_pc;
    logic [PC_W-1:0]   in_npc;
    logic [PC_W-1:0]   in_instr;
    logic              hold;
    logic              bubble;
    logic              flush;
    logic              in_ready;
    logic              out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [PC_W-1:0]   out_pc;
    logic [PC_W-1:0]   out_npc;
    logic [PC_W-1:0]   out_instr;

    modport slave (
        input  in_valid, in_ctrl, in_data, in_pc, in_npc, in_instr,
        input  hold, bubble, flush,
        output in_ready,
        output out_valid, out_ctrl, out_data, out_pc, out_npc, out_instr
    );

    modport master (
        output in_valid, in_ctrl, in_data, in_pc, in_npc, in_instr,
        output hold, bubble, flush,
        input  in_ready,
        input  out_valid, out_ctrl, out_data, out_pc, out_npc, out_instr
    );
endinterface

// File: rtl/pipe_perf_cnt.sv
// -----------------------------------------------------------------------------
// pipe_perf_cnt
// 32-bit event counter with enable; wraps 2^32-1 -> 0, clears on reset.
// Only instantiated when PIPE_STAGE_PERF_EN is defined.
// Ports:
//   clk     - rising-edge clock
//   reset_n - synchronous active-low reset
//   en_i    - count this cycle
//   cnt_o   - current count
// -----------------------------------------------------------------------------
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en_i,
    output logic [31:0] cnt_o
);
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Natural 32-bit overflow provides the wrap to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Carries valid, a control bundle, a data bundle, PC, NPC and the debug
// instruction word. Per-cycle priority: reset > flush > hold > bubble > load.
//   flush  : valid/ctrl cleared, everything else kept (overrides hold)
//   hold   : every register frozen, in_ready low
//   bubble : valid/ctrl cleared, everything else kept
//   load   : all fields take the inputs; ctrl only passes when in_valid
// Invariant: out_valid == 0 implies out_ctrl == 0.
// Parameters: CTRL_W, DATA_W, PC_W, CLEAR_DATA_ON_RESET (0 = data not reset).
// Ports:
//   clk     - rising-edge clock
//   reset_n - synchronous active-low reset
//   stage   - pipe_stage_reg_if.slave (inputs, hazard controls, outputs)
// Optional build macro PIPE_STAGE_PERF_EN adds perf_bubble_cnt,
// perf_flush_cnt, perf_hold_cnt (32-bit wrapping event counters).
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W              = DEF_CTRL_W,
    parameter int DATA_W              = DEF_DATA_W,
    parameter int PC_W                = DEF_PC_W,
    parameter bit CLEAR_DATA_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    pipe_stage_reg_if.slave stage
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0] perf_bubble_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_hold_cnt
`endif
);

    stage_act_e        act;

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [PC_W-1:0]   pc_q,    pc_d;
    logic [PC_W-1:0]   npc_q,   npc_d;
    logic [PC_W-1:0]   instr_q, instr_d;

    // Priority decode (reset is applied in the register processes).
    always_comb begin
        act = ACT_LOAD;
        if (stage.flush) begin
            act = ACT_FLUSH;
        end else if (stage.hold) begin
            act = ACT_HOLD;
        end else if (stage.bubble) begin
            act = ACT_BUBBLE;
        end
    end

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        instr_d = instr_q;
        case (act)
            ACT_FLUSH, ACT_BUBBLE: begin
                // Turn the stage into a NOP but keep PC/instr for debug.
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
            ACT_HOLD: begin
                // keep everything
            end
            default: begin
                valid_d = stage.in_valid;
                // Gating ctrl with valid keeps the ctrl==0-when-invalid invariant.
                ctrl_d  = stage.in_valid ? stage.in_ctrl : '0;
                data_d  = stage.in_data;
                pc_d    = stage.in_pc;
                npc_d   = stage.in_npc;
                instr_d = stage.in_instr;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= '0;
            npc_q   <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            instr_q <= instr_d;
        end
    end

    // The wide data bundle may be left unreset to save reset fan-out;
    // when unreset it simply holds its value through reset.
    generate
        if (CLEAR_DATA_ON_RESET) begin : g_data_rst
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end
        end else begin : g_data_norst
            always_ff @(posedge clk) begin
                if (reset_n) begin
                    data_q <= data_d;
                end
            end
        end
    endgenerate

    assign stage.in_ready  = ~stage.hold;
    assign stage.out_valid = valid_q;
    assign stage.out_ctrl  = ctrl_q;
    assign stage.out_data  = data_q;
    assign stage.out_pc    = pc_q;
    assign stage.out_npc   = npc_q;
    assign stage.out_instr = instr_q;

`ifdef PIPE_STAGE_PERF_EN
    // act already encodes "highest-priority event only".
    pipe_perf_cnt u_bubble_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (act == ACT_BUBBLE),
        .cnt_o   (perf_bubble_cnt)
    );

    pipe_perf_cnt u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (act == ACT_FLUSH),
        .cnt_o   (perf_flush_cnt)
    );

    pipe_perf_cnt u_hold_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (act == ACT_HOLD),
        .cnt_o   (perf_hold_cnt)
    );
`endif

    // Invariant is only meaningful once a reset has been applied.
    logic rst_seen_q;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rst_seen_q <= 1'b1;
        end
    end

    a_ctrl_zero_when_invalid: assert property (
        @(posedge clk) disable iff (!reset_n || !rst_seen_q)
        !valid_q |-> (ctrl_q == '0)
    );

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the 5-stage MIPS core.
- Replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a packed control bundle, a packed data bundle, PC and the debug instruction word, plus an explicit valid bit.
- Supports hold (downstream stall), bubble insertion (load-use hazard) and flush (branch/jump kill), with a defined priority between them.

Parameters:
- CTRL_W, 16, width of packed control bundle (RegWrite, MemToReg, AluOP, ...); zeroed on bubble/flush.
- DATA_W, 128, width of packed data bundle (Imm, Reg1, Reg2, rs/rt/rd, shamt, ...); never zeroed except at reset.
- PC_W, 32, width of PC, NPC and debug instruction fields.
- CLEAR_DATA_ON_RESET, 1, 1 = data bundle reset to 0; 0 = data bundle left unreset.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream stage holds a real instruction.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- in_pc  in  PC_W  upstream PC.
- in_npc  in  PC_W  upstream PC+4.
- in_instr  in  PC_W  upstream instruction word (debug).
- hold  in  1  downstream stall; freeze every register.
- bubble  in  1  hazard stall; insert NOP, keep PC/instr.
- flush  in  1  kill; insert NOP and clear valid.
- in_ready  out  1  stage accepts new input this cycle; equals !hold.
- out_valid  out  1  registered valid.
- out_ctrl  out  CTRL_W  registered control bundle.
- out_data  out  DATA_W  registered data bundle.
- out_pc  out  PC_W  registered PC.
- out_npc  out  PC_W  registered NPC.
- out_instr  out  PC_W  registered instruction word.

Behaviour:
- All state is updated on the rising edge of clk only. Reset is synchronous and active-low.
- Latency: 1 cycle from input to output when loading.
- Reset (reset_n=0) values:
  - out_valid=0, out_ctrl=0, out_pc=0, out_npc=0, out_instr=0.
  - out_data=0 if CLEAR_DATA_ON_RESET, else out_data is unchanged.
  - Reset mid-stall or mid-flush: reset wins unconditionally.
- Priority per cycle: reset > flush > hold > bubble > load.
- flush=1:
  - out_valid<=0, out_ctrl<=0.
  - out_pc, out_npc, out_instr, out_data hold their values.
  - Flush overrides a simultaneous hold, so a killed instruction never survives a stall.
- hold=1 (no flush):
  - Every register keeps its value, including valid.
  - in_ready=0; upstream must not advance.
- bubble=1 (no flush, no hold):
  - out_valid<=0, out_ctrl<=0.
  - out_pc, out_npc, out_instr, out_data hold their values.
  - Repeated bubbles keep the stage a NOP.
- Load (none of the above):
  - All outputs <= corresponding inputs.
  - out_ctrl <= in_ctrl only when in_valid=1; otherwise out_ctrl <= 0 and out_valid <= 0.
  - This guarantees that ctrl=0 whenever valid=0 (invariant).
- Invariant, checked by assertion: out_valid==0 implies out_ctrl==0, at all times after reset.
- in_ready is combinational from hold only; there is no path from in_valid to in_ready.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, three extra outputs are added:
  - perf_bubble_cnt (32-bit): increments on each cycle where bubble is taken.
  - perf_flush_cnt (32-bit): increments on each cycle where flush is taken.
  - perf_hold_cnt (32-bit): increments on each cycle where hold is taken.
- Counter rules:
  - Only the highest-priority event of a cycle counts.
  - Counters wrap at 2^32-1 -> 0.
  - Counters clear on reset.
- When undefined, none of these ports or counters exist; base behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - Per-stage bundle width constants (ID_EX_CTRL_W, ID_EX_DATA_W, EX_MEM_CTRL_W, ...).
  - Field offset constants for packing/unpacking bundles.
  - Constant NOP_CTRL = 0.
- No sub-module is needed for the base block.
- With the macro enabled, a single sub-module pipe_perf_cnt (32-bit wrapping counter with enable) is instantiated three times.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles while in_valid=1, in_ctrl=16'hFFFF -> out_valid=0, out_ctrl=0, out_pc=0 after the first edge.
- Load: in_valid=1, in_ctrl=16'h00A5, in_pc=32'h0040_0010 -> next cycle out_valid=1, out_ctrl=16'h00A5, out_pc=32'h0040_0010.
- Bubble:
  - Stage loaded with pc=32'h0040_0014, ctrl=16'h0031; assert bubble for 2 cycles -> out_valid=0, out_ctrl=0, out_pc stays 32'h0040_0014.
  - Deassert bubble with a new input -> new input loaded.
- Hold vs flush:
  - hold=1 for 3 cycles -> all outputs frozen, in_ready=0.
  - Then hold=1 and flush=1 together -> out_valid=0, out_ctrl=0 next cycle.
- Invalid input: in_valid=0, in_ctrl=16'h1234 -> out_ctrl=0, out_valid=0.
- Perf (PIPE_STAGE_PERF_EN defined):
  - 5 bubble, 2 flush and 3 hold cycles -> counts 5/2/3.
  - Preload a counter to 32'hFFFF_FFFF and take one more event -> counter wraps to 0.
